// File: rtl/watch_calendar_if.sv
// Load bus for watch_calendar: time/date load request with its rejection strobe.
interface watch_calendar_if #(
    parameter int unsigned YEAR_W = 12
);
    logic                set_time;
    logic [YEAR_W+39:0]  bin_time;
    logic [2:0]          set_week;
    logic                set_err;

    modport master (output set_time, bin_time, set_week, input set_err);
    modport slave  (input set_time, bin_time, set_week, output set_err);
endinterface

// File: rtl/watch_calendar.sv
// Calendar/time-of-day counter with leap years, validated load and carry strobes.
// Optional alarm is built only when WATCH_ALARM_EN is defined.
module watch_calendar #(
    parameter int unsigned YEAR_W   = 12,
    parameter int unsigned YEAR_MIN = 1,
    parameter int unsigned YEAR_MAX = 4095,
    parameter int unsigned RST_YEAR = 2021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk1sec,
    watch_calendar_if.slave   load,
    input  logic              mode_12h,
    input  logic [7:0]        alarm_hour,
    input  logic [7:0]        alarm_minute,
    input  logic              alarm_en,
    input  logic              alarm_ack,
    output logic [YEAR_W-1:0] year,
    output logic [7:0]        month,
    output logic [7:0]        day,
    output logic [7:0]        hour,
    output logic [7:0]        minute,
    output logic [7:0]        second,
    output logic [2:0]        week,
    output logic [7:0]        hour_disp,
    output logic              pm,
    output logic              min_pulse,
    output logic              hour_pulse,
    output logic              day_pulse,
    output logic              alarm
);

    localparam logic [YEAR_W-1:0] YearMin  = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YearMax  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] RstYear  = YEAR_W'(RST_YEAR);
    localparam logic [7:0]        RstMonth = 8'd5;
    localparam logic [7:0]        RstDay   = 8'd30;
    localparam logic [2:0]        RstWeek  = 3'd0;

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yy;
        yy = 32'(y);
        return ((yy % 32'd4 == 32'd0) && (yy % 32'd100 != 32'd0)) || (yy % 32'd400 == 32'd0);
    endfunction

    function automatic logic [7:0] max_date(input logic [7:0] m, input logic [YEAR_W-1:0] y);
        logic [7:0] r;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: r = 8'd30;
            8'd2:                    r = is_leap(y) ? 8'd29 : 8'd28;
            default:                 r = 8'd31;
        endcase
        return r;
    endfunction

    logic [YEAR_W-1:0] year_q, year_d;
    logic [7:0]        month_q, month_d, day_q, day_d;
    logic [7:0]        hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic [2:0]        week_q, week_d;
    logic              min_pulse_q, min_pulse_d, hour_pulse_q, hour_pulse_d;
    logic              day_pulse_q, day_pulse_d, set_err_q, set_err_d;

    logic [YEAR_W-1:0] ld_year;
    logic [7:0]        ld_month, ld_day, ld_hour, ld_minute, ld_second;
    logic              ld_valid;

    assign ld_year   = load.bin_time[YEAR_W+39:40];
    assign ld_month  = load.bin_time[39:32];
    assign ld_day    = load.bin_time[31:24];
    assign ld_hour   = load.bin_time[23:16];
    assign ld_minute = load.bin_time[15:8];
    assign ld_second = load.bin_time[7:0];

    assign ld_valid = (ld_year >= YearMin) && (ld_year <= YearMax)
                   && (ld_month >= 8'd1) && (ld_month <= 8'd12)
                   && (ld_day >= 8'd1) && (ld_day <= max_date(ld_month, ld_year))
                   && (ld_hour < 8'd24) && (ld_minute < 8'd60) && (ld_second < 8'd60)
                   && (load.set_week < 3'd7);

    // Carry chain: each wrap implies all lower wraps on the same tick.
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
    assign sec_wrap   = (second_q == 8'd59);
    assign min_wrap   = sec_wrap && (minute_q == 8'd59);
    assign hour_wrap  = min_wrap && (hour_q == 8'd23);
    assign day_wrap   = hour_wrap && (day_q == max_date(month_q, year_q));
    assign month_wrap = day_wrap && (month_q == 8'd12);

    always_comb begin
        year_d       = year_q;
        month_d      = month_q;
        day_d        = day_q;
        hour_d       = hour_q;
        minute_d     = minute_q;
        second_d     = second_q;
        week_d       = week_q;
        min_pulse_d  = 1'b0;
        hour_pulse_d = 1'b0;
        day_pulse_d  = 1'b0;
        set_err_d    = 1'b0;
        if (load.set_time) begin
            if (ld_valid) begin
                year_d   = ld_year;
                month_d  = ld_month;
                day_d    = ld_day;
                hour_d   = ld_hour;
                minute_d = ld_minute;
                second_d = ld_second;
                week_d   = load.set_week;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (clk1sec) begin
            second_d = sec_wrap ? 8'd0 : second_q + 8'd1;
            if (sec_wrap) begin
                min_pulse_d = 1'b1;
                minute_d    = min_wrap ? 8'd0 : minute_q + 8'd1;
            end
            if (min_wrap) begin
                hour_pulse_d = 1'b1;
                hour_d       = hour_wrap ? 8'd0 : hour_q + 8'd1;
            end
            if (hour_wrap) begin
                day_pulse_d = 1'b1;
                week_d      = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
                day_d       = day_wrap ? 8'd1 : day_q + 8'd1;
            end
            if (day_wrap) begin
                month_d = month_wrap ? 8'd1 : month_q + 8'd1;
            end
            if (month_wrap) begin
                year_d = (year_q == YearMax) ? YearMin : year_q + YEAR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            year_q       <= RstYear;
            month_q      <= RstMonth;
            day_q        <= RstDay;
            hour_q       <= 8'd0;
            minute_q     <= 8'd0;
            second_q     <= 8'd0;
            week_q       <= RstWeek;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            hour_q       <= hour_d;
            minute_q     <= minute_d;
            second_q     <= second_d;
            week_q       <= week_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            day_pulse_q  <= day_pulse_d;
            set_err_q    <= set_err_d;
        end
    end

`ifdef WATCH_ALARM_EN
    logic alarm_q, alarm_d;

    // Match is on the post-tick time, so it fires on the edge that lands on hh:mm:00.
    always_comb begin
        alarm_d = alarm_q;
        if (!alarm_en || alarm_ack) begin
            alarm_d = 1'b0;
        end else if (!load.set_time && clk1sec && sec_wrap
                     && (hour_d == alarm_hour) && (minute_d == alarm_minute)) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_hour, alarm_minute, alarm_en, alarm_ack};
    assign alarm = 1'b0;
`endif

    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 8'd0) begin
                hour_disp = 8'd12;
            end else if (hour_q > 8'd12) begin
                hour_disp = hour_q - 8'd12;
            end
        end
    end

    assign pm           = (hour_q >= 8'd12);
    assign year         = year_q;
    assign month        = month_q;
    assign day          = day_q;
    assign hour         = hour_q;
    assign minute       = minute_q;
    assign second       = second_q;
    assign week         = week_q;
    assign min_pulse    = min_pulse_q;
    assign hour_pulse   = hour_pulse_q;
    assign day_pulse    = day_pulse_q;
    assign load.set_err = set_err_q;

endmodule

// File: tb/tb_watch_calendar.sv
// Self-checking bench for watch_calendar: directed scenarios plus randomized run
// against a seconds-of-day / day-count reference model.
module tb_watch_calendar;

    localparam int unsigned YW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk1sec;
    logic          mode_12h;
    logic [7:0]    alarm_hour, alarm_minute;
    logic          alarm_en, alarm_ack;
    logic [YW-1:0] year;
    logic [7:0]    month, day, hour, minute, second, hour_disp;
    logic [2:0]    week;
    logic          pm, min_pulse, hour_pulse, day_pulse, alarm;

    watch_calendar_if #(.YEAR_W(YW)) bus ();

    watch_calendar #(
        .YEAR_W  (YW),
        .YEAR_MIN(1),
        .YEAR_MAX(4095),
        .RST_YEAR(2021)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk1sec     (clk1sec),
        .load        (bus.slave),
        .mode_12h    (mode_12h),
        .alarm_hour  (alarm_hour),
        .alarm_minute(alarm_minute),
        .alarm_en    (alarm_en),
        .alarm_ack   (alarm_ack),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .week        (week),
        .hour_disp   (hour_disp),
        .pm          (pm),
        .min_pulse   (min_pulse),
        .hour_pulse  (hour_pulse),
        .day_pulse   (day_pulse),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: date fields plus time as seconds-of-day.
    int m_year, m_month, m_day, m_sod, m_week;
    bit m_minp, m_hourp, m_dayp, m_err, m_alarm;

    function automatic int dim(int m, int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return leap ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [51:0] mk_bin(int y, int mo, int d, int h, int mi, int s);
        return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    function automatic logic [54:0] mk_exp(int y, int mo, int d, int h, int mi, int s, int wk);
        return {mk_bin(y, mo, d, h, mi, s), 3'(wk)};
    endfunction

    function automatic logic [54:0] model_fields();
        return mk_exp(m_year, m_month, m_day, m_sod / 3600, (m_sod / 60) % 60, m_sod % 60,
                      m_week);
    endfunction

    function automatic logic [54:0] dut_fields();
        return {year, month, day, hour, minute, second, week};
    endfunction

    task automatic model_reset();
        m_year = 2021; m_month = 5; m_day = 30; m_sod = 0; m_week = 0;
        m_minp = 0; m_hourp = 0; m_dayp = 0; m_err = 0; m_alarm = 0;
    endtask

    task automatic model_edge();
        int y, mo, d, h, mi, s, wk;
        bit ok;
        y  = int'(bus.bin_time[51:40]);
        mo = int'(bus.bin_time[39:32]);
        d  = int'(bus.bin_time[31:24]);
        h  = int'(bus.bin_time[23:16]);
        mi = int'(bus.bin_time[15:8]);
        s  = int'(bus.bin_time[7:0]);
        wk = int'(bus.set_week);
        m_minp = 0; m_hourp = 0; m_dayp = 0; m_err = 0;
        if (bus.set_time) begin
            ok = (y >= 1) && (y <= 4095) && (mo >= 1) && (mo <= 12) && (d >= 1)
              && (d <= dim(mo, y)) && (h < 24) && (mi < 60) && (s < 60) && (wk < 7);
            if (ok) begin
                m_year = y; m_month = mo; m_day = d; m_week = wk;
                m_sod = h * 3600 + mi * 60 + s;
            end else begin
                m_err = 1;
            end
        end else if (clk1sec) begin
            m_sod   = (m_sod + 1) % 86400;
            m_minp  = (m_sod % 60 == 0);
            m_hourp = (m_sod % 3600 == 0);
            m_dayp  = (m_sod == 0);
            if (m_dayp) begin
                m_week = (m_week + 1) % 7;
                m_day  = m_day + 1;
                if (m_day > dim(m_month, m_year)) begin
                    m_day   = 1;
                    m_month = m_month + 1;
                    if (m_month > 12) begin
                        m_month = 1;
                        m_year  = (m_year == 4095) ? 1 : m_year + 1;
                    end
                end
            end
        end
`ifdef WATCH_ALARM_EN
        if (!alarm_en || alarm_ack) begin
            m_alarm = 0;
        end else if (!bus.set_time && clk1sec && (m_sod % 60 == 0)
                     && (m_sod / 3600 == int'(alarm_hour))
                     && ((m_sod / 60) % 60 == int'(alarm_minute))) begin
            m_alarm = 1;
        end
`endif
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int y, int mo, int d, int h, int mi, int s, int wk, bit tick);
        bus.set_time = 1'b1;
        bus.bin_time = mk_bin(y, mo, d, h, mi, s);
        bus.set_week = 3'(wk);
        clk1sec      = tick;
        cycle();
        bus.set_time = 1'b0;
        clk1sec      = 1'b0;
    endtask

    task automatic do_tick();
        clk1sec = 1'b1;
        cycle();
        clk1sec = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dut_fields() !== mk_exp(2021, 5, 30, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_fields: got %h want %h", dut_fields(),
                     mk_exp(2021, 5, 30, 0, 0, 0, 0));
        end
        n_tests++;
        if ({min_pulse, hour_pulse, day_pulse, bus.set_err, alarm} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {min_pulse, hour_pulse, day_pulse, bus.set_err, alarm});
        end
        rst = 1'b1;
        cycle();
        do_tick();
        n_tests++;
        if (dut_fields() !== mk_exp(2021, 5, 30, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL first_tick: got %h want %h", dut_fields(),
                     mk_exp(2021, 5, 30, 0, 0, 1, 0));
        end
        n_tests++;
        if ({min_pulse, hour_pulse, day_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL first_tick_pulses: got %b want 000",
                     {min_pulse, hour_pulse, day_pulse});
        end
    endtask

    task automatic test_leap_rollover();
        do_load(2024, 2, 28, 23, 59, 59, 3, 1'b0);
        n_tests++;
        if (dut_fields() !== mk_exp(2024, 2, 28, 23, 59, 59, 3)) begin
            n_fail++;
            $display("FAIL leap_load: got %h want %h", dut_fields(),
                     mk_exp(2024, 2, 28, 23, 59, 59, 3));
        end
        do_tick();
        n_tests++;
        if (dut_fields() !== mk_exp(2024, 2, 29, 0, 0, 0, 4)) begin
            n_fail++;
            $display("FAIL leap_tick: got %h want %h", dut_fields(),
                     mk_exp(2024, 2, 29, 0, 0, 0, 4));
        end
        n_tests++;
        if ({min_pulse, hour_pulse, day_pulse} !== 3'b111) begin
            n_fail++;
            $display("FAIL leap_pulses: got %b want 111", {min_pulse, hour_pulse, day_pulse});
        end
        cycle();
        n_tests++;
        if ({min_pulse, hour_pulse, day_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL leap_pulses_clear: got %b want 000",
                     {min_pulse, hour_pulse, day_pulse});
        end
    endtask

    task automatic test_century();
        do_load(2100, 2, 28, 23, 59, 59, 1, 1'b0);
        do_tick();
        n_tests++;
        if (dut_fields() !== mk_exp(2100, 3, 1, 0, 0, 0, 2)) begin
            n_fail++;
            $display("FAIL century_2100: got %h want %h", dut_fields(),
                     mk_exp(2100, 3, 1, 0, 0, 0, 2));
        end
        do_load(2000, 2, 29, 12, 0, 0, 2, 1'b0);
        n_tests++;
        if ({dut_fields(), bus.set_err} !== {mk_exp(2000, 2, 29, 12, 0, 0, 2), 1'b0}) begin
            n_fail++;
            $display("FAIL load_2000_0229: got %h/%b want %h/0", dut_fields(), bus.set_err,
                     mk_exp(2000, 2, 29, 12, 0, 0, 2));
        end
        do_load(2023, 2, 29, 10, 10, 10, 0, 1'b0);
        n_tests++;
        if ({dut_fields(), bus.set_err} !== {mk_exp(2000, 2, 29, 12, 0, 0, 2), 1'b1}) begin
            n_fail++;
            $display("FAIL reject_2023_0229: got %h/%b want %h/1", dut_fields(), bus.set_err,
                     mk_exp(2000, 2, 29, 12, 0, 0, 2));
        end
        cycle();
        n_tests++;
        if (bus.set_err !== 1'b0) begin
            n_fail++;
            $display("FAIL set_err_one_cycle: got %b want 0", bus.set_err);
        end
        do_load(0, 1, 1, 0, 0, 0, 0, 1'b0);
        n_tests++;
        if (bus.set_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_year0: got %b want 1", bus.set_err);
        end
        do_load(2022, 6, 1, 0, 0, 0, 7, 1'b0);
        n_tests++;
        if (bus.set_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_week7: got %b want 1", bus.set_err);
        end
    endtask

    task automatic test_year_wrap();
        do_load(4095, 12, 31, 23, 59, 59, 6, 1'b0);
        do_tick();
        n_tests++;
        if (dut_fields() !== mk_exp(1, 1, 1, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL year_wrap: got %h want %h", dut_fields(), mk_exp(1, 1, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_set_priority();
        do_load(2030, 7, 15, 8, 30, 45, 1, 1'b1);
        n_tests++;
        if ({dut_fields(), min_pulse} !== {mk_exp(2030, 7, 15, 8, 30, 45, 1), 1'b0}) begin
            n_fail++;
            $display("FAIL set_over_tick: got %h want %h", dut_fields(),
                     mk_exp(2030, 7, 15, 8, 30, 45, 1));
        end
    endtask

    task automatic test_12h();
        int h, exp_disp;
        for (int i = 0; i < 8; i++) begin
            h = (i == 0) ? 0 : (i == 1) ? 13 : (i == 2) ? 12 : int'($urandom_range(0, 23));
            mode_12h = (i != 7);
            do_load(2022, 1, 1, h, 0, 0, 6, 1'b0);
            exp_disp = !mode_12h ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
            n_tests++;
            if ({hour_disp, pm} !== {8'(exp_disp), (h >= 12)}) begin
                n_fail++;
                $display("FAIL disp_12h h=%0d mode=%b: got %0d/%b want %0d/%b", h, mode_12h,
                         hour_disp, pm, exp_disp, (h >= 12));
            end
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_alarm();
        alarm_en = 1'b1; alarm_hour = 8'd7; alarm_minute = 8'd0; alarm_ack = 1'b0;
        do_load(2022, 3, 3, 6, 59, 58, 4, 1'b0);
        do_tick();
        n_tests++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_early: got %b want 0", alarm);
        end
        do_tick();
`ifdef WATCH_ALARM_EN
        repeat (3) begin
            n_tests++;
            if (alarm !== 1'b1) begin
                n_fail++;
                $display("FAIL alarm_held: got %b want 1", alarm);
            end
            cycle();
        end
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        n_tests++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_ack: got %b want 0", alarm);
        end
`else
        n_tests++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_disabled: got %b want 0", alarm);
        end
`endif
    endtask

    task automatic test_random();
        int y, mo, d, h, mi, s, wk, exp_disp;
        for (int i = 0; i < 3000; i++) begin
            bus.set_time = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 9) < 7) begin
                y  = ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(1, 4095));
                mo = ($urandom_range(0, 2) == 0) ? 12 : int'($urandom_range(1, 12));
                d  = dim(mo, y) - int'($urandom_range(0, 2));
                h  = ($urandom_range(0, 1) == 0) ? 23 : int'($urandom_range(0, 23));
                mi = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 59));
                s  = int'($urandom_range(50, 59));
                wk = int'($urandom_range(0, 6));
            end else begin
                y  = int'($urandom_range(0, 4095));
                mo = int'($urandom_range(0, 13));
                d  = int'($urandom_range(0, 32));
                h  = int'($urandom_range(0, 25));
                mi = int'($urandom_range(0, 61));
                s  = int'($urandom_range(0, 61));
                wk = int'($urandom_range(0, 7));
            end
            bus.bin_time = mk_bin(y, mo, d, h, mi, s);
            bus.set_week = 3'(wk);
            clk1sec      = ($urandom_range(0, 9) < 8);
            mode_12h     = $urandom_range(0, 1);
            alarm_en     = ($urandom_range(0, 9) != 0);
            alarm_ack    = ($urandom_range(0, 19) == 0);
            alarm_hour   = 8'(m_sod / 3600);
            alarm_minute = 8'(((m_sod / 60) + int'($urandom_range(0, 1))) % 60);
            cycle();
            n_tests++;
            if (dut_fields() !== model_fields()) begin
                n_fail++;
                $display("FAIL rand_fields[%0d]: got %h want %h", i, dut_fields(),
                         model_fields());
            end
            n_tests++;
            if ({min_pulse, hour_pulse, day_pulse, bus.set_err, alarm}
                !== {m_minp, m_hourp, m_dayp, m_err, m_alarm}) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b want %b", i,
                         {min_pulse, hour_pulse, day_pulse, bus.set_err, alarm},
                         {m_minp, m_hourp, m_dayp, m_err, m_alarm});
            end
            exp_disp = m_sod / 3600;
            if (mode_12h) exp_disp = (exp_disp == 0) ? 12 : (exp_disp > 12) ? exp_disp - 12
                                                                            : exp_disp;
            n_tests++;
            if (hour_disp !== 8'(exp_disp)) begin
                n_fail++;
                $display("FAIL rand_disp[%0d]: got %0d want %0d", i, hour_disp, exp_disp);
            end
        end
        bus.set_time = 1'b0;
        clk1sec      = 1'b0;
        alarm_ack    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clk1sec = 1'b0; mode_12h = 1'b0;
        alarm_hour = 8'd0; alarm_minute = 8'd0; alarm_en = 1'b0; alarm_ack = 1'b0;
        bus.set_time = 1'b0; bus.bin_time = '0; bus.set_week = 3'd0;
        test_reset();
        test_leap_rollover();
        test_century();
        test_year_wrap();
        test_set_priority();
        test_12h();
        test_alarm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
